// File: rtl/vehicle_sensor_conditioner.sv
// Raw loop-detector conditioning for roads A/B: 2-flop sync, tick debounce, sticky request latch, arrival counters.
// Optional stuck-active detection is built when SENSOR_STUCK_DETECT_EN is defined.
module vehicle_sensor_conditioner #(
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned STUCK_TICKS    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sa_raw,
    input  logic       sb_raw,
    input  logic       ga,
    input  logic       gb,
    output logic       Sa,
    output logic       Sb,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b,
    output logic       stuck_a,
    output logic       stuck_b
);

    localparam int          NCH    = 2;
    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DCNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int unsigned CNT_W  = 8;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Reject parameter values the datapath cannot represent.
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 1");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_TICKS must be >= 1");
    end
    if (STUCK_TICKS < 1) begin : g_bad_stuck
        $error("STUCK_TICKS must be >= 1");
    end

    logic [NCH-1:0]    raw_c;
    logic [NCH-1:0]    grn_c;
    logic [NCH-1:0]    sync1_q;
    logic [NCH-1:0]    sync2_q;
    logic [NCH-1:0]    clean_q;
    logic [NCH-1:0]    clean_d;
    logic [NCH-1:0]    req_q;
    logic [NCH-1:0]    req_d;
    logic [NCH-1:0]    force_c;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic              tick_c;
    logic [DCNT_W-1:0] dcnt_q [NCH];
    logic [DCNT_W-1:0] dcnt_d [NCH];
    logic [CNT_W-1:0]  cnt_q  [NCH];
    logic [CNT_W-1:0]  cnt_d  [NCH];

    assign raw_c  = {sb_raw, sa_raw};
    assign grn_c  = {gb, ga};
    assign tick_c = (div_q == DIV_LAST);

    // Prescaler, debounce, arrival counters and request latch next-state.
    always_comb begin
        div_d = tick_c ? '0 : div_q + DIV_W'(1);
        for (int ch = 0; ch < NCH; ch++) begin
            clean_d[ch] = clean_q[ch];
            dcnt_d[ch]  = dcnt_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            req_d[ch]   = req_q[ch];

            if (tick_c) begin
                if (sync2_q[ch] == clean_q[ch]) begin
                    dcnt_d[ch] = '0;
                end else if (dcnt_q[ch] == DCNT_LAST) begin
                    clean_d[ch] = sync2_q[ch];
                    dcnt_d[ch]  = '0;
                end else begin
                    dcnt_d[ch] = dcnt_q[ch] + DCNT_W'(1);
                end
            end

            if (clean_d[ch] && !clean_q[ch] && (cnt_q[ch] != CNT_MAX)) begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end

            // Set dominates; a green only clears once the road is empty.
            req_d[ch] = force_c[ch] | clean_q[ch] | (req_q[ch] & ~(grn_c[ch] & ~clean_q[ch]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            req_q   <= '0;
            div_q   <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                dcnt_q[ch] <= '0;
                cnt_q[ch]  <= '0;
            end
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            req_q   <= req_d;
            div_q   <= div_d;
            for (int ch = 0; ch < NCH; ch++) begin
                dcnt_q[ch] <= dcnt_d[ch];
                cnt_q[ch]  <= cnt_d[ch];
            end
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int unsigned          STK_W   = $clog2(STUCK_TICKS + 1);
    localparam logic [STK_W-1:0]     STK_MAX = STK_W'(STUCK_TICKS);

    logic [STK_W-1:0] stk_q [NCH];
    logic [STK_W-1:0] stk_d [NCH];
    logic [NCH-1:0]   stuck_q;
    logic [NCH-1:0]   stuck_d;

    // Count ticks spent active; saturate and flag, drop everything once the road empties.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            stk_d[ch]   = stk_q[ch];
            stuck_d[ch] = 1'b0;
            if (!clean_q[ch]) begin
                stk_d[ch] = '0;
            end else if (tick_c && (stk_q[ch] != STK_MAX)) begin
                stk_d[ch] = stk_q[ch] + STK_W'(1);
            end
            stuck_d[ch] = clean_q[ch] && (stk_d[ch] == STK_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_q <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                stk_q[ch] <= '0;
            end
        end else begin
            stuck_q <= stuck_d;
            for (int ch = 0; ch < NCH; ch++) begin
                stk_q[ch] <= stk_d[ch];
            end
        end
    end

    assign force_c = stuck_q;
    assign stuck_a = stuck_q[0];
    assign stuck_b = stuck_q[1];
`else
    assign force_c = '0;
    assign stuck_a = 1'b0;
    assign stuck_b = 1'b0;
`endif

    assign Sa    = req_q[0];
    assign Sb    = req_q[1];
    assign cnt_a = cnt_q[0];
    assign cnt_b = cnt_q[1];

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench for vehicle_sensor_conditioner with a per-cycle behavioural model and literal spot checks.
// Build with SENSOR_STUCK_DETECT_EN defined to exercise the stuck-sensor path.
module tb_vehicle_sensor_conditioner;

    localparam int TDIV = 4;
    localparam int DEB  = 3;
    localparam int STK  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sa_raw = 1'b1;
    logic       sb_raw = 1'b1;
    logic       ga = 1'b0;
    logic       gb = 1'b0;
    logic       Sa;
    logic       Sb;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic       stuck_a;
    logic       stuck_b;

    int total = 0;
    int bad   = 0;

    vehicle_sensor_conditioner #(
        .TICK_DIV       (TDIV),
        .DEBOUNCE_TICKS (DEB),
        .STUCK_TICKS    (STK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sa_raw  (sa_raw),
        .sb_raw  (sb_raw),
        .ga      (ga),
        .gb      (gb),
        .Sa      (Sa),
        .Sb      (Sb),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .stuck_a (stuck_a),
        .stuck_b (stuck_b)
    );

    always #5 clk = ~clk;

    // Behavioural model: cycle count since reset decides ticks, mismatch run-length decides flips.
    int m_cyc;
    int m_run [2];
    int m_cnt [2];
    int m_stk [2];
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_clean [2];
    bit m_req [2];
    bit m_stuck [2];
    bit m_valid = 1'b0;
    bit m_tick;
    bit m_old;
    bit [1:0] m_raw;
    bit [1:0] m_g;

    always @(posedge clk) begin
        m_raw = {sb_raw, sa_raw};
        m_g   = {gb, ga};
        if (rst) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_run[c] = 0; m_clean[c] = 0;
                m_req[c] = 0; m_cnt[c] = 0; m_stk[c] = 0; m_stuck[c] = 0;
            end
        end else begin
            m_tick = ((m_cyc % TDIV) == TDIV - 1);
            for (int c = 0; c < 2; c++) begin
                m_old    = m_clean[c];
                m_req[c] = m_stuck[c] || m_old || (m_req[c] && !m_g[c]);
`ifdef SENSOR_STUCK_DETECT_EN
                if (!m_old) begin
                    m_stk[c] = 0;
                end else if (m_tick && m_stk[c] < STK) begin
                    m_stk[c] = m_stk[c] + 1;
                end
                m_stuck[c] = m_old && (m_stk[c] == STK);
`endif
                if (m_tick) begin
                    if (m_s2[c] != m_old) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == DEB) begin
                            m_clean[c] = m_s2[c];
                            m_run[c]   = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                if (!m_old && m_clean[c] && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
                m_s2[c] = m_s1[c];
                m_s1[c] = m_raw[c];
            end
            m_cyc = m_cyc + 1;
        end
    end

    logic [19:0] m_exp;
    logic [19:0] m_act;

    always @(negedge clk) begin
        if (m_valid) begin
            m_exp = {m_req[0], m_req[1], 8'(m_cnt[0]), 8'(m_cnt[1]), m_stuck[0], m_stuck[1]};
            m_act = {Sa, Sb, cnt_a, cnt_b, stuck_a, stuck_b};
            total++;
            if (m_act !== m_exp) begin
                bad++;
                $display("FAIL model_cycle t=%0t act=%h exp=%h", $time, m_act, m_exp);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count negedges until Sa reaches val, giving up after maxc.
    task automatic wait_sa(input logic val, input int maxc, output int n);
        n = 0;
        while (Sa !== val && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic clear_both();
        sa_raw = 0; sb_raw = 0;
        cycles(20);
        ga = 1; gb = 1;
        cycles(1);
        ga = 0; gb = 0;
        cycles(1);
        check("clear_both", int'({Sa, Sb}), 0);
    endtask

    int n;
    int sb_seen;

    initial begin
        // Reset with both sensors active.
        @(negedge clk);
        check("t1_reset_edge1", int'({Sa, Sb, cnt_a, cnt_b, stuck_a, stuck_b}), 0);
        @(negedge clk);
        check("t1_reset_edge2", int'({Sa, Sb, cnt_a, cnt_b, stuck_a, stuck_b}), 0);
        rst = 0;
        n = 0;
        while (!(Sa === 1'b1 && Sb === 1'b1) && n < 15) begin
            @(negedge clk);
            n++;
        end
        check("t1_req_after_reset", int'({Sa, Sb}), 3);
        check("t1_latency", n, 13);
        check("t1_cnt", int'({cnt_a, cnt_b}), 16'h0101);

        clear_both();

        // Single arrival on A, then served.
        sa_raw = 1;
        wait_sa(1'b1, 20, n);
        check("t2_latency_ok", int'(n >= 12 && n <= 15), 1);
        check("t2_cnt_a", int'(cnt_a), 2);
        sa_raw = 0;
        cycles(20);
        check("t2_sticky", int'(Sa), 1);
        ga = 1;
        cycles(1);
        ga = 0;
        check("t2_cleared", int'(Sa), 0);

        // Glitch rejection on B.
        sb_seen = 0;
        for (int i = 0; i < 40; i++) begin
            sb_raw = (i % 6 == 0);
            cycles(1);
            if (Sb === 1'b1) sb_seen = 1;
        end
        sb_raw = 0;
        cycles(10);
        check("t3_sb_quiet", sb_seen | int'(Sb), 0);
        check("t3_cnt_b", int'(cnt_b), 1);

        // Arrival while green: set wins, then drop after clean falls.
        ga = 1;
        sa_raw = 1;
        cycles(20);
        check("t4_set_wins", int'(Sa), 1);
        sa_raw = 0;
        wait_sa(1'b0, 20, n);
        check("t4_drop_latency_ok", int'(n >= 12 && n <= 15), 1);
        check("t4_cnt_a", int'(cnt_a), 3);
        ga = 0;
        cycles(2);

        // Counter saturation on B.
        for (int i = 0; i < 300; i++) begin
            sb_raw = 1;
            cycles(16);
            sb_raw = 0;
            cycles(16);
            if (i == 99) check("t5_cnt_mid", int'(cnt_b), 101);
        end
        check("t5_cnt_sat", int'(cnt_b), 255);
        sb_raw = 1;
        cycles(16);
        sb_raw = 0;
        cycles(16);
        check("t5_cnt_hold", int'(cnt_b), 255);
        clear_both();

        // Long-held sensor on A.
        sa_raw = 1;
        cycles(80);
`ifdef SENSOR_STUCK_DETECT_EN
        check("t6_stuck_set", int'(stuck_a), 1);
`else
        check("t6_stuck_off", int'(stuck_a), 0);
`endif
        ga = 1;
        cycles(1);
        ga = 0;
        cycles(1);
        check("t6_sa_held", int'(Sa), 1);
        sa_raw = 0;
        n = 0;
        while (stuck_a !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_stuck_clear", int'(stuck_a), 0);
        cycles(20);
        check("t6_sa_still_latched", int'(Sa), 1);
        ga = 1;
        cycles(1);
        ga = 0;
        cycles(1);
        check("t6_normal_clear", int'(Sa), 0);
        check("t6_stuck_b", int'(stuck_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
